uart_tx_ctrl: RTL

//  Frame sequencer for the UART transmitter. Accepts a parallel word over a

---
 rtl/uart_tx_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, DATA_W data bits LSB first, optional parity, stop.
// Latency: frame begins the clk after the accepting edge; each bit period lasts PRESCALE clks.
// Backpressure: data_ready is high only in IDLE; words offered while busy are ignored.
// Optional: define UART_TX_TWO_STOP_EN for two stop bit periods per frame.
module uart_tx_ctrl #(
  parameter int DATA_W   = 8,
  parameter int PRESCALE = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] p_data,
  input  logic              par_en,
  input  logic              par_typ,
  output logic              data_ready,
  output logic              busy,
  output logic [1:0]        mux_sel,
  output logic              ser_data,
  output logic              parity_bit
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              parity_q, parity_d;
  logic              busy_q, busy_d;
  logic [1:0]        mux_q, mux_d;
  logic              bit_end;

`ifdef UART_TX_TWO_STOP_EN
  // Marks that the first of the two stop periods has already elapsed.
  logic              stop_q, stop_d;
`endif

  assign bit_end    = (cnt_q == CNT_LAST);
  assign data_ready = (state_q == IDLE);
  assign busy       = busy_q;
  assign mux_sel    = mux_q;
  assign ser_data   = shift_q[0];
  assign parity_bit = parity_q;

  // Next-state: frame sequencing, bit-period timing and data shifting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_en_d = par_en_q;
    parity_d = parity_q;
    busy_d   = busy_q;
    mux_d    = mux_q;
`ifdef UART_TX_TWO_STOP_EN
    stop_d   = stop_q;
`endif

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d  = START;
          shift_d  = p_data;
          par_en_d = par_en;
          parity_d = (^p_data) ^ par_typ;
          busy_d   = 1'b1;
          mux_d    = MUX_START;
          cnt_d    = '0;
          idx_d    = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          mux_d   = MUX_DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = PARITY;
              mux_d   = MUX_PAR;
            end else begin
              state_d = STOP;
              mux_d   = MUX_STOP;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          mux_d   = MUX_STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
          if (!stop_q) begin
            stop_d = 1'b1;
          end else begin
            stop_d  = 1'b0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        mux_d   = MUX_STOP;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any frame in flight immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      busy_q   <= 1'b0;
      mux_q    <= MUX_STOP;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_en_q <= par_en_d;
      parity_q <= parity_d;
      busy_q   <= busy_d;
      mux_q    <= mux_d;
    end
  end

`ifdef UART_TX_TWO_STOP_EN
  // Stop-period counter for the second stop bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= stop_d;
    end
  end
`endif

endmodule
